// File: rtl/alu_operand_loader_if.sv
// Handshake bus between the operand loader, its upstream beat source and the ALU consumer.
//   din/din_valid/din_ready : narrow input beat channel (A, B, opcode)
//   a/b/op/out_valid/out_ready : captured transaction presented to the ALU
interface alu_operand_loader_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned OPW   = 3
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;

    // Upstream/consumer side: drives beats and consumes the transaction
    modport master (
        output din, din_valid, out_ready,
        input  din_ready, a, b, op, out_valid
    );

    // Loader side
    modport slave (
        input  din, din_valid, out_ready,
        output din_ready, a, b, op, out_valid
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand-capture stage for the Mini ALU: collects A, B and opcode beats from a
// narrow bus, then holds them stable with out_valid until the ALU consumes them.
//   clk, rst_n : clock and asynchronous active-low reset
//   abort      : synchronous restart of the current transaction (highest priority)
//   bus        : beat input channel and captured-transaction output channel
//   phase      : current state encoding (S_A=0, S_B=1, S_OP=2, S_HOLD=3)
//   busy       : a transaction is partially or fully loaded
//   txn_count  : wrapping count of consumed transactions
module alu_operand_loader #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned OPW   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       abort,
    alu_operand_loader_if.slave        bus,
    output logic [1:0]                 phase,
    output logic                       busy,
    output logic [7:0]                 txn_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_HOLD = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic             din_ready_c;

    // Input channel is open in every loading state
    assign din_ready_c = (state_q != S_HOLD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            txn_count_q <= txn_count_d;
        end
    end

    // Next-state and capture logic; abort overrides any beat or consumption
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        txn_count_d = txn_count_q;

        if (abort) begin
            state_d     = S_A;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_A: begin
                    if (bus.din_valid) begin
                        a_d     = bus.din;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (bus.din_valid) begin
                        b_d     = bus.din;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (bus.din_valid) begin
                        op_d        = bus.din[OPW-1:0];
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = S_A;
                        out_valid_d = 1'b0;
                        txn_count_d = txn_count_q + CNT_W'(1);
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign bus.din_ready = din_ready_c;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.out_valid = out_valid_q;
    assign phase         = state_q;
    assign busy          = (state_q != S_A);
    assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader.
module tb_alu_operand_loader;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned OPW   = 3;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic [1:0] phase;
    logic       busy;
    logic [7:0] txn_count;

    int n_checks;
    int n_fail;

    alu_operand_loader_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_operand_loader #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .bus       (bus.slave),
        .phase     (phase),
        .busy      (busy),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                             input logic [2:0] eop);
        check_eq({tag, "_a"}, 32'(bus.a), 32'(ea));
        check_eq({tag, "_b"}, 32'(bus.b), 32'(eb));
        check_eq({tag, "_op"}, 32'(bus.op), 32'(eop));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        abort         = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        #2;
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_din_ready", 32'(bus.din_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_txn", 32'(txn_count), 32'd0);
        check_out("rst", 6'h00, 6'h00, 3'd0);
        tick();
        check_eq("rst_hold_phase", 32'(phase), 32'd0);
        rst_n = 1'b1;

        // Async reset asserted mid-S_B with A loaded
        bus.din = 6'h2A; bus.din_valid = 1'b1;
        tick();
        check_eq("sb_phase", 32'(phase), 32'd1);
        check_eq("sb_a", 32'(bus.a), 32'h2A);
        bus.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_phase", 32'(phase), 32'd0);
        check_out("midrst", 6'h00, 6'h00, 3'd0);
        check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_txn", 32'(txn_count), 32'd0);
        #1;
        rst_n = 1'b1;
        bus.din = 6'h11; bus.din_valid = 1'b1;
        tick();
        check_eq("post_rst_a", 32'(bus.a), 32'h11);
        check_eq("post_rst_phase", 32'(phase), 32'd1);
        bus.din_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_sb_phase", 32'(phase), 32'd0);

        // Single transaction, continuous valid
        bus.din_valid = 1'b1;
        bus.din = 6'h15; tick();
        bus.din = 6'h3C; tick();
        bus.din = 6'h3D; tick();
        bus.din = 6'h3F;           // ignored while holding
        for (int i = 0; i < 3; i++) begin
            check_eq("single_valid", 32'(bus.out_valid), 32'd1);
            check_eq("single_phase", 32'(phase), 32'd3);
            check_eq("single_din_ready", 32'(bus.din_ready), 32'd0);
            check_out("single", 6'h15, 6'h3C, 3'd5);
            tick();
        end
        check_eq("single_valid4", 32'(bus.out_valid), 32'd1);
        check_out("single4", 6'h15, 6'h3C, 3'd5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.din_valid = 1'b0;
        check_eq("single_done_valid", 32'(bus.out_valid), 32'd0);
        check_eq("single_done_phase", 32'(phase), 32'd0);
        check_eq("single_done_txn", 32'(txn_count), 32'd1);

        // Gapped input: phase advances only on accepted beats
        begin
            logic [5:0] beats [3];
            beats[0] = 6'h15; beats[1] = 6'h3C; beats[2] = 6'h3D;
            for (int k = 0; k < 3; k++) begin
                bus.din = beats[k];
                for (int g = 0; g < 2; g++) begin
                    bus.din_valid = 1'b0;
                    tick();
                    check_eq("gap_idle_phase", 32'(phase), 32'(k));
                end
                bus.din_valid = 1'b1;
                tick();
                check_eq("gap_beat_phase", 32'(phase), 32'(k + 1));
            end
        end
        bus.din_valid = 1'b0;
        check_eq("gap_valid", 32'(bus.out_valid), 32'd1);
        check_out("gap", 6'h15, 6'h3C, 3'd5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("gap_txn", 32'(txn_count), 32'd2);

        // Back-to-back: A=k+1, B=k+0x20, opcode beat 0x38|k (op=k)
        bus.din_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int k;
            k = i / 4;
            case (i % 4)
                0: bus.din = 6'(k + 1);
                1: bus.din = 6'(k + 32);
                2: bus.din = 6'(56 + k);
                default: bus.din = 6'h3F; // must not be taken as the next A
            endcase
            tick();
            check_eq("b2b_phase", 32'(phase), 32'((i + 1) % 4));
            check_eq("b2b_valid", 32'(bus.out_valid), ((i % 4) == 2) ? 32'd1 : 32'd0);
            if ((i % 4) == 2)
                check_out("b2b", 6'(k + 1), 6'(k + 32), 3'(k));
            if ((i % 4) == 3)
                check_eq("b2b_a_kept", 32'(bus.a), 32'(k + 1));
        end
        bus.din_valid = 1'b0; bus.out_ready = 1'b0;
        check_eq("b2b_txn", 32'(txn_count), 32'd5);

        // Abort in S_OP with a valid opcode beat
        bus.din_valid = 1'b1;
        bus.din = 6'h0A; tick();
        bus.din = 6'h0B; tick();
        check_eq("abort_op_pre_phase", 32'(phase), 32'd2);
        bus.din = 6'h07; abort = 1'b1;
        tick();
        abort = 1'b0; bus.din_valid = 1'b0;
        check_eq("abort_op_phase", 32'(phase), 32'd0);
        check_out("abort_op", 6'h0A, 6'h0B, 3'd2);
        check_eq("abort_op_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_op_txn", 32'(txn_count), 32'd5);

        // Abort in S_HOLD together with out_ready
        bus.din_valid = 1'b1;
        bus.din = 6'h21; tick();
        bus.din = 6'h12; tick();
        bus.din = 6'h04; tick();
        bus.din_valid = 1'b0;
        check_eq("abort_hold_pre_valid", 32'(bus.out_valid), 32'd1);
        abort = 1'b1; bus.out_ready = 1'b1;
        tick();
        abort = 1'b0; bus.out_ready = 1'b0;
        check_eq("abort_hold_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_hold_phase", 32'(phase), 32'd0);
        check_eq("abort_hold_txn", 32'(txn_count), 32'd5);
        check_out("abort_hold", 6'h21, 6'h12, 3'd4);

        // Counter wrap from a fresh reset; every opcode value exercised
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check_eq("wrap_start_txn", 32'(txn_count), 32'd0);
        for (int t = 1; t <= 256; t++) begin
            bus.din_valid = 1'b1;
            bus.din = 6'(t);        tick();
            bus.din = 6'(t + 7);    tick();
            bus.din = 6'(t);        tick();
            bus.din_valid = 1'b0;
            check_eq("wrap_op", 32'(bus.op), 32'(t % 8));
            bus.out_ready = 1'b1;   tick();
            bus.out_ready = 1'b0;
            if (t == 255)
                check_eq("wrap_txn_255", 32'(txn_count), 32'd255);
            if (t == 256)
                check_eq("wrap_txn_256", 32'(txn_count), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
